// File: rtl/ex_mem_skid.sv
// Purpose : EX->MEM pipeline register built as a two-entry skid buffer, with sticky ALU flags and optional overflow trap.
// Latency : 1 cycle from accept to mem_* when the buffer is EMPTY or drains in the accept cycle.
// Backpr. : ex_ready is registered and drops only in TWO (or while trap is set); it never depends combinationally on mem_ready.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ex_valid / ex_ready        upstream handshake
//   ex_data, ex_ofl/cout/z     ALU result and flags
//   ex_wr_reg, ex_wr_en        destination register index and write enable
//   ex_flag_upd                accepted result updates the sticky flags
//   ex_chk_ofl, trap_clr       overflow-trap check and trap clear
//   flush                      synchronous flush, empties the buffer
//   mem_valid / mem_ready      downstream handshake
//   mem_data, mem_wr_reg, mem_wr_en, mem_ofl/cout/z   head entry fields
//   flags                      sticky {Z, C, V}
//   trap                       overflow trap pending
//
// Build option: define EX_OFL_TRAP_EN to include the overflow trap; otherwise trap is tied to 0.
module ex_mem_skid #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ex_valid,
  output logic         ex_ready,
  input  logic [W-1:0] ex_data,
  input  logic         ex_ofl,
  input  logic         ex_cout,
  input  logic         ex_z,
  input  logic [2:0]   ex_wr_reg,
  input  logic         ex_wr_en,
  input  logic         ex_flag_upd,
  input  logic         ex_chk_ofl,
  input  logic         flush,
  input  logic         trap_clr,
  output logic         mem_valid,
  input  logic         mem_ready,
  output logic [W-1:0] mem_data,
  output logic [2:0]   mem_wr_reg,
  output logic         mem_wr_en,
  output logic         mem_ofl,
  output logic         mem_cout,
  output logic         mem_z,
  output logic [2:0]   flags,
  output logic         trap
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [W-1:0] data;
    logic [2:0]   wr_reg;
    logic         wr_en;
    logic         ofl;
    logic         cout;
    logic         z;
  } entry_t;

  state_t state_q, state_d;
  entry_t head_q, head_d;   // entry presented to MEM
  entry_t skid_q, skid_d;   // second entry, only meaningful in TWO
  entry_t in_ent;
  logic   ex_ready_q, ex_ready_d;
  logic   [2:0] flags_q;
  logic   trap_d;
  logic   accept, drain;

  assign mem_valid = (state_q != EMPTY);
  assign accept    = ex_valid && ex_ready_q;
  assign drain     = mem_valid && mem_ready;

  always_comb begin
    in_ent        = '0;
    in_ent.data   = ex_data;
    in_ent.wr_reg = ex_wr_reg;
    in_ent.wr_en  = ex_wr_en;
    in_ent.ofl    = ex_ofl;
    in_ent.cout   = ex_cout;
    in_ent.z      = ex_z;
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            head_d  = in_ent;
          end
        end
        ONE: begin
          if (accept && drain) begin
            head_d = in_ent;
          end else if (accept) begin
            state_d = TWO;
            skid_d  = in_ent;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          // ex_ready is 0 in TWO, so only a drain can happen here.
          if (drain) begin
            state_d = ONE;
            head_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

`ifdef EX_OFL_TRAP_EN
  logic trap_q;

  // A trapping accept wins over a simultaneous clear; a flushed accept never traps.
  always_comb begin
    trap_d = trap_q;
    if (accept && !flush && ex_chk_ofl && ex_ofl) begin
      trap_d = 1'b1;
    end else if (trap_clr) begin
      trap_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
    end
  end

  assign trap = trap_q;
`else
  logic unused_trap_inputs;
  assign unused_trap_inputs = ^{ex_chk_ofl, trap_clr};
  assign trap_d = 1'b0;
  assign trap   = 1'b0;
`endif

  // ready is computed from next state so it is registered yet exact.
  assign ex_ready_d = (state_d != TWO) && !trap_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      ex_ready_q <= 1'b1;
      flags_q    <= 3'b000;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      ex_ready_q <= ex_ready_d;
      if (accept && ex_flag_upd && !flush) begin
        flags_q <= {ex_z, ex_cout, ex_ofl};
      end
    end
  end

  assign ex_ready   = ex_ready_q;
  assign mem_data   = head_q.data;
  assign mem_wr_reg = head_q.wr_reg;
  assign mem_wr_en  = head_q.wr_en;
  assign mem_ofl    = head_q.ofl;
  assign mem_cout   = head_q.cout;
  assign mem_z      = head_q.z;
  assign flags      = flags_q;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Purpose : directed table-driven bench for ex_mem_skid plus hand-written reset and trap sequences.
// Latency : each vector is driven after a rising edge and its outputs sampled 1 time unit after the next edge.
// Backpr. : mem_ready is driven per vector to build EMPTY/ONE/TWO occupancy.
module tb_ex_mem_skid;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [15:0] ex_data = '0;
  logic        ex_ofl = 1'b0, ex_cout = 1'b0, ex_z = 1'b0;
  logic [2:0]  ex_wr_reg = '0;
  logic        ex_wr_en = 1'b0, ex_flag_upd = 1'b0, ex_chk_ofl = 1'b0;
  logic        flush = 1'b0, trap_clr = 1'b0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_data;
  logic [2:0]  mem_wr_reg;
  logic        mem_wr_en, mem_ofl, mem_cout, mem_z;
  logic [2:0]  flags;
  logic        trap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mem_skid #(.W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_data(ex_data),
    .ex_ofl(ex_ofl), .ex_cout(ex_cout), .ex_z(ex_z),
    .ex_wr_reg(ex_wr_reg), .ex_wr_en(ex_wr_en), .ex_flag_upd(ex_flag_upd),
    .ex_chk_ofl(ex_chk_ofl), .flush(flush), .trap_clr(trap_clr),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_data(mem_data),
    .mem_wr_reg(mem_wr_reg), .mem_wr_en(mem_wr_en),
    .mem_ofl(mem_ofl), .mem_cout(mem_cout), .mem_z(mem_z),
    .flags(flags), .trap(trap)
  );

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic [2:0]  zco;     // {z, cout, ofl} inputs
    logic [2:0]  wreg;
    logic        wen, upd, chk, fl, tclr, mr;
    logic        e_rdy, e_mv;
    logic [15:0] e_d;
    logic [2:0]  e_reg;
    logic        e_wen;
    logic [2:0]  e_mf;    // expected {mem_z, mem_cout, mem_ofl}
    logic [2:0]  e_flags;
    logic        e_trap;
  } vec_t;

  function automatic vec_t mk(
    input logic v, input logic [15:0] d, input logic [2:0] zco, input logic [2:0] wreg,
    input logic wen, input logic upd, input logic chk, input logic fl, input logic tclr,
    input logic mr, input logic e_rdy, input logic e_mv, input logic [15:0] e_d,
    input logic [2:0] e_reg, input logic e_wen, input logic [2:0] e_mf,
    input logic [2:0] e_flags, input logic e_trap);
    vec_t r;
    r.v = v; r.d = d; r.zco = zco; r.wreg = wreg; r.wen = wen; r.upd = upd;
    r.chk = chk; r.fl = fl; r.tclr = tclr; r.mr = mr;
    r.e_rdy = e_rdy; r.e_mv = e_mv; r.e_d = e_d; r.e_reg = e_reg; r.e_wen = e_wen;
    r.e_mf = e_mf; r.e_flags = e_flags; r.e_trap = e_trap;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step(input string tag, input int idx, input vec_t t);
    ex_valid    = t.v;
    ex_data     = t.d;
    {ex_z, ex_cout, ex_ofl} = t.zco;
    ex_wr_reg   = t.wreg;
    ex_wr_en    = t.wen;
    ex_flag_upd = t.upd;
    ex_chk_ofl  = t.chk;
    flush       = t.fl;
    trap_clr    = t.tclr;
    mem_ready   = t.mr;
    @(posedge clk);
    #1;
    chk({tag, ".ex_ready"},  idx, 32'(ex_ready),  32'(t.e_rdy));
    chk({tag, ".mem_valid"}, idx, 32'(mem_valid), 32'(t.e_mv));
    chk({tag, ".flags"},     idx, 32'(flags),     32'(t.e_flags));
    chk({tag, ".trap"},      idx, 32'(trap),      32'(t.e_trap));
    if (t.e_mv) begin
      chk({tag, ".mem_data"},   idx, 32'(mem_data),   32'(t.e_d));
      chk({tag, ".mem_wr_reg"}, idx, 32'(mem_wr_reg), 32'(t.e_reg));
      chk({tag, ".mem_wr_en"},  idx, 32'(mem_wr_en),  32'(t.e_wen));
      chk({tag, ".mem_flags"},  idx, 32'({mem_z, mem_cout, mem_ofl}), 32'(t.e_mf));
    end
  endtask

  vec_t tbl[16];
  vec_t hs;

  initial begin
    //            v  d         zco     reg   wen upd chk fl tclr mr | rdy mv e_d      e_reg wen e_mf    e_flags trap
    tbl[0]  = mk(1, 16'h1234, 3'b000, 3'd3, 1, 0, 0, 0, 0, 1,  1, 1, 16'h1234, 3'd3, 1, 3'b000, 3'b000, 0); // single accept
    tbl[1]  = mk(0, 16'h0000, 3'b000, 3'd0, 0, 0, 0, 0, 0, 1,  1, 0, 16'h0000, 3'd0, 0, 3'b000, 3'b000, 0); // drain -> EMPTY
    tbl[2]  = mk(0, 16'h0000, 3'b000, 3'd0, 0, 0, 0, 0, 0, 1,  1, 0, 16'h0000, 3'd0, 0, 3'b000, 3'b000, 0); // ready in EMPTY, no underflow
    tbl[3]  = mk(1, 16'hAAAA, 3'b000, 3'd1, 0, 0, 0, 0, 0, 0,  1, 1, 16'hAAAA, 3'd1, 0, 3'b000, 3'b000, 0); // ONE under backpressure
    tbl[4]  = mk(1, 16'h5555, 3'b000, 3'd2, 1, 0, 0, 0, 0, 0,  0, 1, 16'hAAAA, 3'd1, 0, 3'b000, 3'b000, 0); // TWO, ready drops
    tbl[5]  = mk(1, 16'hFFFF, 3'b111, 3'd7, 1, 1, 0, 0, 0, 0,  0, 1, 16'hAAAA, 3'd1, 0, 3'b000, 3'b000, 0); // not accepted, head stable
    tbl[6]  = mk(0, 16'h0000, 3'b000, 3'd0, 0, 0, 0, 0, 0, 1,  1, 1, 16'h5555, 3'd2, 1, 3'b000, 3'b000, 0); // AAAA out, 5555 next
    tbl[7]  = mk(0, 16'h0000, 3'b000, 3'd0, 0, 0, 0, 0, 0, 1,  1, 0, 16'h0000, 3'd0, 0, 3'b000, 3'b000, 0); // 5555 out -> EMPTY
    tbl[8]  = mk(1, 16'h0000, 3'b110, 3'd4, 1, 1, 0, 0, 0, 1,  1, 1, 16'h0000, 3'd4, 1, 3'b110, 3'b110, 0); // flag update
    tbl[9]  = mk(1, 16'h0042, 3'b001, 3'd5, 1, 0, 0, 0, 0, 1,  1, 1, 16'h0042, 3'd5, 1, 3'b001, 3'b110, 0); // no update, accept+drain
    tbl[10] = mk(1, 16'h0007, 3'b001, 3'd6, 1, 1, 0, 0, 0, 0,  0, 1, 16'h0042, 3'd5, 1, 3'b001, 3'b001, 0); // ONE -> TWO, flags 001
    tbl[11] = mk(1, 16'hBEEF, 3'b100, 3'd0, 1, 1, 0, 1, 0, 0,  1, 0, 16'h0000, 3'd0, 0, 3'b000, 3'b001, 0); // flush in TWO
    tbl[12] = mk(1, 16'h1111, 3'b000, 3'd1, 1, 0, 0, 0, 0, 0,  1, 1, 16'h1111, 3'd1, 1, 3'b000, 3'b001, 0); // refill
    tbl[13] = mk(1, 16'h2222, 3'b111, 3'd2, 1, 1, 0, 1, 0, 1,  1, 0, 16'h0000, 3'd0, 0, 3'b000, 3'b001, 0); // flush blocks accept+flags
    tbl[14] = mk(1, 16'h3333, 3'b010, 3'd3, 1, 0, 0, 0, 0, 0,  1, 1, 16'h3333, 3'd3, 1, 3'b010, 3'b001, 0); // lands in EMPTY
    tbl[15] = mk(0, 16'h0000, 3'b000, 3'd0, 0, 0, 0, 0, 0, 0,  1, 1, 16'h3333, 3'd3, 1, 3'b010, 3'b001, 0); // hold

    // Asynchronous reset with no clock edge involved.
    #1 rst_n = 1'b0;
    #1;
    chk("reset.ex_ready",  0, 32'(ex_ready),  32'd1);
    chk("reset.mem_valid", 0, 32'(mem_valid), 32'd0);
    chk("reset.mem_data",  0, 32'(mem_data),  32'd0);
    chk("reset.mem_misc",  0, 32'({mem_wr_reg, mem_wr_en, mem_ofl, mem_cout, mem_z}), 32'd0);
    chk("reset.flags",     0, 32'(flags),     32'd0);
    chk("reset.trap",      0, 32'(trap),      32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      step("vec", i, tbl[i]);
    end

    // Fill to TWO, then pulse reset between edges.
    hs = mk(1, 16'hAAAA, 3'b100, 3'd1, 1, 1, 0, 0, 0, 0,  0, 1, 16'h3333, 3'd3, 1, 3'b010, 3'b100, 0);
    step("arst_fill", 0, hs);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.mem_valid", 1, 32'(mem_valid), 32'd0);
    chk("arst.flags",     1, 32'(flags),     32'd0);
    chk("arst.ex_ready",  1, 32'(ex_ready),  32'd1);
    chk("arst.mem_data",  1, 32'(mem_data),  32'd0);
    ex_valid = 1'b0;
    ex_flag_upd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    hs = mk(1, 16'hCCCC, 3'b000, 3'd7, 1, 0, 0, 0, 0, 0,  1, 1, 16'hCCCC, 3'd7, 1, 3'b000, 3'b000, 0);
    step("post_rst", 0, hs);
    hs = mk(0, 16'h0000, 3'b000, 3'd0, 0, 0, 0, 0, 0, 1,  1, 0, 16'h0000, 3'd0, 0, 3'b000, 3'b000, 0);
    step("post_rst", 1, hs);

`ifdef EX_OFL_TRAP_EN
    hs = mk(1, 16'h0BAD, 3'b001, 3'd1, 1, 0, 1, 0, 0, 1,  0, 1, 16'h0BAD, 3'd1, 1, 3'b001, 3'b000, 1);
    step("trap", 0, hs);   // trap set, entry still enqueued
    hs = mk(0, 16'h0000, 3'b000, 3'd0, 0, 0, 0, 0, 0, 1,  0, 0, 16'h0000, 3'd0, 0, 3'b000, 3'b000, 1);
    step("trap", 1, hs);   // drained, trap holds ready low
    hs = mk(1, 16'hDEAD, 3'b000, 3'd2, 1, 0, 0, 0, 1, 1,  1, 0, 16'h0000, 3'd0, 0, 3'b000, 3'b000, 0);
    step("trap", 2, hs);   // trap_clr, offered data not accepted
    hs = mk(1, 16'h0ACE, 3'b001, 3'd3, 1, 0, 1, 0, 1, 1,  0, 1, 16'h0ACE, 3'd3, 1, 3'b001, 3'b000, 1);
    step("trap", 3, hs);   // trapping accept beats trap_clr
    hs = mk(0, 16'h0000, 3'b000, 3'd0, 0, 0, 0, 0, 1, 1,  1, 0, 16'h0000, 3'd0, 0, 3'b000, 3'b000, 0);
    step("trap", 4, hs);
`else
    hs = mk(1, 16'h0BAD, 3'b001, 3'd1, 1, 0, 1, 0, 0, 1,  1, 1, 16'h0BAD, 3'd1, 1, 3'b001, 3'b000, 0);
    step("notrap", 0, hs); // overflow check ignored
    hs = mk(0, 16'h0000, 3'b000, 3'd0, 0, 0, 0, 0, 1, 1,  1, 0, 16'h0000, 3'd0, 0, 3'b000, 3'b000, 0);
    step("notrap", 1, hs);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
